// File: rtl/accel_pkg.sv
// accel_pkg: types and constants shared by the scheduler, accelerator_core and accelerator_regs.
package accel_pkg;

  localparam int ACCEL_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;

endpackage

// File: rtl/accel_rr_arb.sv
// accel_rr_arb: combinational round-robin arbiter; the search starts at ptr_i and wraps.
module accel_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // One extra bit keeps ptr+off from wrapping early when NUM_REQ is not a power of two.
      sum = {1'b0, ptr_i} + (ID_W+1)'(off);
      if (sum >= (ID_W+1)'(NUM_REQ)) begin
        sum = sum - (ID_W+1)'(NUM_REQ);
      end
      cand = sum[ID_W-1:0];
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/accel_sched.sv
// accel_sched: shares one accelerator_core between NUM_REQ requesters, one job at a time.
// Optional feature: define ACCEL_SCHED_STATS_EN for per-requester job and overflow counters.
module accel_sched
  import accel_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = ACCEL_DATA_W,
  parameter int CORE_LAT = 2,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  input  logic [NUM_REQ-1:0]        rsp_ready_i,
  output logic [DATA_W-1:0]         rsp_result_o,
  output logic                      rsp_overflow_o,
  output logic [ID_W-1:0]           rsp_id_o,
  output logic [DATA_W-1:0]         core_a_o,
  output logic [DATA_W-1:0]         core_b_o,
  input  logic [DATA_W-1:0]         core_result_i,
  input  logic                      core_overflow_i,
`ifdef ACCEL_SCHED_STATS_EN
  output logic [NUM_REQ*16-1:0]     stat_jobs_o,
  output logic [15:0]               stat_ovf_o,
  input  logic                      stat_clr_i,
`endif
  output logic                      busy_o
);

  localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  if (CORE_LAT < 1) begin : g_bad_lat
    $error("accel_sched: CORE_LAT must be at least 1");
  end

  sched_state_e        state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]   core_a_q, core_a_d, core_b_q, core_b_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_overflow_q, rsp_overflow_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0]  arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic                arb_any;

  accel_rr_arb #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    // NOTE: every *_d starts as its *_q so no path through the case leaves a variable unassigned (no latch).
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    lat_cnt_d      = lat_cnt_q;
    core_a_d       = core_a_q;
    core_b_d       = core_b_q;
    rsp_result_d   = rsp_result_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_id_d       = rsp_id_q;
    rsp_valid_d    = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
              core_a_d = req_a_i[i*DATA_W +: DATA_W];
              core_b_d = req_b_i[i*DATA_W +: DATA_W];
            end
          end
          id_d     = arb_idx;
          rr_ptr_d = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_W'(CORE_LAT - 1);
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          rsp_result_d       = core_result_i;
          rsp_overflow_d     = core_overflow_i;
          rsp_id_d           = id_q;
          rsp_valid_d        = '0;
          rsp_valid_d[id_q]  = 1'b1;
          state_d            = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready_i[id_q]) begin
          rsp_valid_d = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      id_q           <= '0;
      lat_cnt_q      <= '0;
      core_a_q       <= '0;
      core_b_q       <= '0;
      rsp_result_q   <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_id_q       <= '0;
      rsp_valid_q    <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      id_q           <= id_d;
      lat_cnt_q      <= lat_cnt_d;
      core_a_q       <= core_a_d;
      core_b_q       <= core_b_d;
      rsp_result_q   <= rsp_result_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_id_q       <= rsp_id_d;
      rsp_valid_q    <= rsp_valid_d;
    end
  end

  assign req_ready_o    = (state_q == IDLE) ? arb_gnt : '0;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_result_o   = rsp_result_q;
  assign rsp_overflow_o = rsp_overflow_q;
  assign rsp_id_o       = rsp_id_q;
  assign core_a_o       = core_a_q;
  assign core_b_o       = core_b_q;
  assign busy_o         = (state_q != IDLE);

`ifdef ACCEL_SCHED_STATS_EN
  logic [15:0] jobs_q [NUM_REQ];
  logic [15:0] jobs_d [NUM_REQ];
  logic [15:0] ovf_cnt_q, ovf_cnt_d;
  logic        rsp_hs;

  assign rsp_hs = (state_q == RESP) && rsp_ready_i[id_q];

  // Clear takes priority over a same-cycle handshake; counters stick at all-ones.
  always_comb begin
    jobs_d    = jobs_q;
    ovf_cnt_d = ovf_cnt_q;
    if (stat_clr_i) begin
      for (int i = 0; i < NUM_REQ; i++) jobs_d[i] = '0;
      ovf_cnt_d = '0;
    end else if (rsp_hs) begin
      if (jobs_q[id_q] != 16'hFFFF) jobs_d[id_q] = jobs_q[id_q] + 16'd1;
      if (rsp_overflow_q && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  // NOTE: the counter array is small flop storage with a visible reset value, so it is reset explicitly.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      for (int i = 0; i < NUM_REQ; i++) jobs_q[i] <= '0;
      ovf_cnt_q <= '0;
    end else begin
      jobs_q    <= jobs_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_jobs_o[g*16 +: 16] = jobs_q[g];
  end
  assign stat_ovf_o = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_accel_sched.sv
// tb_accel_sched: directed, scoreboarded bench for accel_sched with a 2-cycle adder core model.
module tb_accel_sched;

  localparam int NR = 4;
  localparam int DW = 16;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*DW-1:0] req_a, req_b;
  logic [DW-1:0]   rsp_result, core_a, core_b, core_result;
  logic            rsp_ovf, core_ovf, busy;
  logic [1:0]      rsp_id;
`ifdef ACCEL_SCHED_STATS_EN
  logic [NR*16-1:0] stat_jobs;
  logic [15:0]      stat_ovf;
  logic             stat_clr;
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t exp_q[$];

  logic [15:0] rr_a [4] = '{16'h0100, 16'h0202, 16'h7FFF, 16'hF000};
  logic [15:0] rr_b [4] = '{16'h0001, 16'h0303, 16'h0001, 16'h2000};
  int          rr_order [5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  accel_sched dut (
    .wb_clk_i        (clk),
    .wb_rst_i        (rst_n),
    .req_valid_i     (req_valid),
    .req_ready_o     (req_ready),
    .req_a_i         (req_a),
    .req_b_i         (req_b),
    .rsp_valid_o     (rsp_valid),
    .rsp_ready_i     (rsp_ready),
    .rsp_result_o    (rsp_result),
    .rsp_overflow_o  (rsp_ovf),
    .rsp_id_o        (rsp_id),
    .core_a_o        (core_a),
    .core_b_o        (core_b),
    .core_result_i   (core_result),
    .core_overflow_i (core_ovf),
`ifdef ACCEL_SCHED_STATS_EN
    .stat_jobs_o     (stat_jobs),
    .stat_ovf_o      (stat_ovf),
    .stat_clr_i      (stat_clr),
`endif
    .busy_o          (busy)
  );

  // Core model: 17-bit add, result stable two edges after the operands change.
  logic [16:0] core_s1, core_s2;
  always @(posedge clk) begin
    core_s1 <= {1'b0, core_a} + {1'b0, core_b};
    core_s2 <= core_s1;
  end
  assign core_result = core_s2[15:0];
  assign core_ovf    = core_s2[16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int id);
    logic [3:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic set_req(input int id, input logic [15:0] a, input logic [15:0] b, input logic v);
    req_a[id*DW +: DW] = a;
    req_b[id*DW +: DW] = b;
    req_valid[id]      = v;
  endtask

  task automatic push_exp(input int id, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    exp_t        e;
    s     = {1'b0, a} + {1'b0, b};
    e.id  = 2'(id);
    e.res = s[15:0];
    e.ovf = s[16];
    exp_q.push_back(e);
  endtask

  task automatic rsp_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n === 1'b1 && rsp_valid != '0 && (rsp_valid & rsp_ready) != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(rsp_valid), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(onehot(int'(e.id))));
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_result", 32'(rsp_result), 32'(e.res));
          check("rsp_overflow", 32'(rsp_ovf), 32'(e.ovf));
        end
      end
    end
  endtask

  task automatic wait_idle();
    int c = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && c < 50) begin
      @(negedge clk);
      #3;
      c++;
    end
    check("drain_timeout", 32'(c < 50), 32'(1));
  endtask

  task automatic run_job(input int id, input logic [15:0] a, input logic [15:0] b);
    int c = 0;
    @(negedge clk);
    set_req(id, a, b, 1'b1);
    #1;
    while (req_ready[id] !== 1'b1 && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("job_ready", 32'(req_ready), 32'(onehot(id)));
    push_exp(id, a, b);
    @(negedge clk);
    req_valid[id] = 1'b0;
    wait_idle();
  endtask

  initial begin
    int got;
    int c;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = '1;
`ifdef ACCEL_SCHED_STATS_EN
    stat_clr  = 1'b0;
`endif
    fork
      rsp_monitor();
    join_none

    // Reset state
    #12;
    check("rst_core_a", 32'(core_a), 32'(0));
    check("rst_core_b", 32'(core_b), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_result", 32'(rsp_result), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Single job on requester 1 with explicit latency checks
    @(negedge clk);
    set_req(1, 16'h1234, 16'h0001, 1'b1);
    #1;
    check("single_ready", 32'(req_ready), 32'(4'b0010));
    push_exp(1, 16'h1234, 16'h0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_busy", 32'(busy), 32'(1));
    check("single_core_a", 32'(core_a), 32'(16'h1234));
    check("single_core_b", 32'(core_b), 32'(16'h0001));
    @(negedge clk); #1;
    check("single_lat1", 32'(rsp_valid), 32'(0));
    @(negedge clk); #1;
    check("single_lat2", 32'(rsp_valid), 32'(0));
    @(negedge clk); #1;
    check("single_lat3", 32'(rsp_valid), 32'(4'b0010));
    wait_idle();
    check("idle_holds_core_a", 32'(core_a), 32'(16'h1234));

    // Overflow on requester 3; pointer then wraps to 0
    run_job(3, 16'hFFFF, 16'h0001);
`ifdef ACCEL_SCHED_STATS_EN
    check("stat_ovf_one", 32'(stat_ovf), 32'(1));
    check("stat_jobs1", 32'(stat_jobs[1*16 +: 16]), 32'(1));
    check("stat_jobs3", 32'(stat_jobs[3*16 +: 16]), 32'(1));
`endif

    // Round-robin with all four requesters holding valid
    @(negedge clk);
    for (int i = 0; i < 4; i++) set_req(i, rr_a[i], rr_b[i], 1'b1);
    got = 0;
    c   = 0;
    while (got < 5 && c < 100) begin
      #1;
      if (req_ready != '0) begin
        check("rr_grant", 32'(req_ready), 32'(onehot(rr_order[got])));
        push_exp(rr_order[got], rr_a[rr_order[got]], rr_b[rr_order[got]]);
        got++;
      end
      if (got < 5) @(negedge clk);
      c++;
    end
    check("rr_count", 32'(got), 32'(5));
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle();

    // Response backpressure on requester 2 while requester 0 waits
    rsp_ready = '0;
    @(negedge clk);
    set_req(2, 16'hABCD, 16'h1111, 1'b1);
    #1;
    check("bp_ready", 32'(req_ready), 32'(4'b0100));
    push_exp(2, 16'hABCD, 16'h1111);
    @(negedge clk);
    req_valid[2] = 1'b0;
    set_req(0, 16'h0005, 16'h0007, 1'b1);
    c = 0;
    while (rsp_valid == '0 && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    check("bp_rsp_seen", 32'(rsp_valid), 32'(4'b0100));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check("bp_hold_valid", 32'(rsp_valid), 32'(4'b0100));
      check("bp_hold_result", 32'(rsp_result), 32'(16'hBCDE));
      check("bp_hold_busy", 32'(busy), 32'(1));
      check("bp_hold_ready", 32'(req_ready), 32'(0));
    end
    @(negedge clk);
    rsp_ready = '1;
    #1;
    check("bp_release_ready", 32'(req_ready), 32'(0));
    @(negedge clk);
    #1;
    check("bp_next_ready", 32'(req_ready), 32'(4'b0001));
    check("bp_next_idle", 32'(busy), 32'(0));
    push_exp(0, 16'h0005, 16'h0007);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("bp_next_busy", 32'(busy), 32'(1));
    wait_idle();

    // Asynchronous reset during WAIT discards the job
    @(negedge clk);
    set_req(1, 16'h4444, 16'h1111, 1'b1);
    #1;
    check("rstmid_ready", 32'(req_ready), 32'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rstmid_core_a", 32'(core_a), 32'(0));
    check("rstmid_core_b", 32'(core_b), 32'(0));
    check("rstmid_busy", 32'(busy), 32'(0));
    check("rstmid_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rstmid_rsp_id", 32'(rsp_id), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 16'h0A0A, 16'h0101, 1'b1);
    set_req(2, 16'h0B0B, 16'h0202, 1'b1);
    #1;
    check("rstmid_grant0", 32'(req_ready), 32'(4'b0001));
    push_exp(0, 16'h0A0A, 16'h0101);
    @(negedge clk);
    req_valid = '0;
    wait_idle();

`ifdef ACCEL_SCHED_STATS_EN
    // Clear coincident with a handshake on requester 2
    check("stat_pre_clr0", 32'(stat_jobs[0 +: 16]), 32'(1));
    rsp_ready = '0;
    @(negedge clk);
    set_req(2, 16'h0001, 16'h0002, 1'b1);
    #1;
    check("clr_ready", 32'(req_ready), 32'(4'b0100));
    push_exp(2, 16'h0001, 16'h0002);
    @(negedge clk);
    req_valid = '0;
    c = 0;
    while (rsp_valid == '0 && c < 20) begin
      @(negedge clk);
      #1;
      c++;
    end
    stat_clr  = 1'b1;
    rsp_ready = '1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("clr_jobs2", 32'(stat_jobs[2*16 +: 16]), 32'(0));
    check("clr_jobs0", 32'(stat_jobs[0 +: 16]), 32'(0));
    check("clr_ovf", 32'(stat_ovf), 32'(0));
    wait_idle();
`endif

    check("queue_empty", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
